// File: rtl/charattr_row_fetcher.sv
// charattr_row_fetcher
//   Text-mode row prefetcher. One text row of COLUMNS cell words is burst
//   from SDRAM into the fill bank of a ping-pong pair while the other bank
//   (the display bank) is read by the pixel pipeline by column index.
//
// Ports
//   clk, reset          clock, async active-low reset (release synchronised)
//   frame_start         latch base/scroll, restart row fetching at fetch 0
//   line_start          per visible line; every CHAR_HEIGHT lines swaps banks
//   base_address        page base address
//   scroll_row          first memory row displayed (>= ROWS reads as 0)
//   rd_request          one-cycle burst request
//   rd_address          burst start address, held until the next request
//   rd_burst_length     constant COLUMNS
//   rd_available        rd_data valid this cycle
//   rd_data             burst word
//   cell_index          display column to read
//   charattr            registered cell word, 0 while row_valid is low
//   char_row            scanline within the current text row
//   row_valid           display bank holds a complete row
//   underrun            pulse: swapped to a bank whose fill was incomplete
//   fetch_error         pulse: burst aborted after TIMEOUT idle cycles
module charattr_row_fetcher #(
  parameter int COLUMNS     = 80,
  parameter int ROWS        = 51,
  parameter int CHAR_HEIGHT = 20,
  parameter int ADDR_WIDTH  = 23,
  parameter int DATA_WIDTH  = 32,
  parameter int ROW_STRIDE  = 512,
  parameter int TIMEOUT     = 255
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           frame_start,
  input  logic                           line_start,
  input  logic [ADDR_WIDTH-1:0]          base_address,
  input  logic [$clog2(ROWS)-1:0]        scroll_row,
  output logic                           rd_request,
  output logic [ADDR_WIDTH-1:0]          rd_address,
  output logic [8:0]                     rd_burst_length,
  input  logic                           rd_available,
  input  logic [DATA_WIDTH-1:0]          rd_data,
  input  logic [$clog2(COLUMNS)-1:0]     cell_index,
  output logic [DATA_WIDTH-1:0]          charattr,
  output logic [$clog2(CHAR_HEIGHT)-1:0] char_row,
  output logic                           row_valid,
  output logic                           underrun,
  output logic                           fetch_error
);
  localparam int SW  = $clog2(ROWS);
  localparam int CIW = $clog2(COLUMNS);
  localparam int CRW = $clog2(CHAR_HEIGHT);
  localparam int WCW = $clog2(COLUMNS + 1);
  localparam int FCW = $clog2(ROWS + 1);
  localparam int TW  = $clog2(TIMEOUT + 1);
  localparam int RSW = $clog2(2 * ROWS);

  typedef enum logic [1:0] {IDLE, REQUEST, RECEIVE, DRAIN} state_t;

  // Assert asynchronously, release two clocks later.
  logic [1:0] rst_sync;
  logic       rst_n;
  always_ff @(posedge clk or negedge reset)
    if (!reset) rst_sync <= '0;
    else        rst_sync <= {rst_sync[0], 1'b1};
  assign rst_n = rst_sync[1];

  assign rd_burst_length = 9'(COLUMNS);

  state_t                state;
  logic                  started, boundary_pending, disp_bank, cur_bank;
  logic                  fetch_pend, fetch_bank;
  logic [1:0]            ready;
  logic [ADDR_WIDTH-1:0] base_l, fetch_addr;
  logic [SW-1:0]         scroll_l;
  logic [FCW-1:0]        fetch_cnt;   // fetches queued this frame
  logic [WCW-1:0]        word_cnt;
  logic [TW-1:0]         tmo_cnt;
  logic [DATA_WIDTH-1:0] bank_q [2][COLUMNS];

  logic                  ls, boundary, incomplete, queue, abort;
  logic                  q_bank, disp_nxt, rv_nxt;
  logic [SW-1:0]         scroll_eff, q_scroll;
  logic [RSW-1:0]        row_sum, row_wrap;
  logic [ADDR_WIDTH-1:0] q_addr;

  always_comb begin
    // frame_start swallows a coincident line_start
    ls         = line_start & started & ~frame_start;
    boundary   = ls & (boundary_pending | (char_row == CRW'(CHAR_HEIGHT - 1)));
    // the bank about to be displayed is the current fill bank (~disp_bank)
    incomplete = boundary & ~ready[~disp_bank];
    queue      = frame_start | (boundary & (fetch_cnt < FCW'(ROWS)));
    abort      = frame_start | incomplete;
    // after a swap the new fill bank is the old display bank
    q_bank     = frame_start ? 1'b0 : disp_bank;
    scroll_eff = ({1'b0, scroll_row} >= (SW + 1)'(ROWS)) ? '0 : scroll_row;
    q_scroll   = frame_start ? scroll_eff : scroll_l;
    row_sum    = RSW'(q_scroll) + (frame_start ? '0 : RSW'(fetch_cnt));
    row_wrap   = (row_sum >= RSW'(ROWS)) ? row_sum - RSW'(ROWS) : row_sum;
    q_addr     = (frame_start ? base_address : base_l)
               + ADDR_WIDTH'(row_wrap) * ADDR_WIDTH'(ROW_STRIDE);
    // frame_start parks display on bank 1 so the first boundary shows bank 0
    disp_nxt   = frame_start ? 1'b1 : (boundary ? ~disp_bank : disp_bank);
    rv_nxt     = frame_start ? 1'b0 : (boundary ? ready[~disp_bank] : row_valid);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      rd_request       <= 1'b0;
      rd_address       <= '0;
      char_row         <= '0;
      row_valid        <= 1'b0;
      underrun         <= 1'b0;
      fetch_error      <= 1'b0;
      started          <= 1'b0;
      boundary_pending <= 1'b0;
      disp_bank        <= 1'b0;
      cur_bank         <= 1'b0;
      fetch_pend       <= 1'b0;
      fetch_bank       <= 1'b0;
      ready            <= '0;
      base_l           <= '0;
      fetch_addr       <= '0;
      scroll_l         <= '0;
      fetch_cnt        <= '0;
      word_cnt         <= '0;
      tmo_cnt          <= '0;
    end else begin
      rd_request  <= 1'b0;
      underrun    <= 1'b0;
      fetch_error <= 1'b0;

      case (state)
        IDLE:
          // hold off if a new fetch is being queued this very cycle
          if (fetch_pend && !queue && !incomplete) begin
            state      <= REQUEST;
            rd_request <= 1'b1;
            rd_address <= fetch_addr;
            cur_bank   <= fetch_bank;
            fetch_pend <= 1'b0;
          end
        REQUEST: begin
          word_cnt <= '0;
          tmo_cnt  <= '0;
          state    <= abort ? DRAIN : RECEIVE;
        end
        default: begin  // RECEIVE, DRAIN
          if (rd_available) begin
            word_cnt <= word_cnt + WCW'(1);
            tmo_cnt  <= '0;
            if (word_cnt == WCW'(COLUMNS - 1)) begin
              state <= IDLE;
              if (state == RECEIVE && !abort) ready[cur_bank] <= 1'b1;
            end else if (state == RECEIVE && abort) begin
              state <= DRAIN;
            end
          end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
            state <= IDLE;
            if (state == RECEIVE) fetch_error <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
            if (state == RECEIVE && abort) state <= DRAIN;
          end
        end
      endcase

      if (frame_start) begin
        started          <= 1'b1;
        base_l           <= base_address;
        scroll_l         <= scroll_eff;
        fetch_cnt        <= FCW'(1);
        ready            <= '0;
        boundary_pending <= 1'b1;
        disp_bank        <= 1'b1;
        char_row         <= '0;
        row_valid        <= 1'b0;
      end else if (ls) begin
        if (boundary) begin
          disp_bank        <= ~disp_bank;
          char_row         <= '0;
          boundary_pending <= 1'b0;
          row_valid        <= ready[~disp_bank];
          underrun         <= incomplete;
          if (fetch_cnt < FCW'(ROWS)) fetch_cnt <= fetch_cnt + FCW'(1);
        end else begin
          char_row <= char_row + CRW'(1);
        end
      end

      // an unstarted fetch for the abandoned bank is dropped
      if (incomplete) fetch_pend <= 1'b0;
      if (queue) begin
        fetch_pend     <= 1'b1;
        fetch_bank     <= q_bank;
        fetch_addr     <= q_addr;
        ready[q_bank]  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk)
    if (state == RECEIVE && rd_available)
      bank_q[cur_bank][word_cnt[CIW-1:0]] <= rd_data;

  // Looked up with next-cycle bank/valid so charattr tracks row_valid exactly.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      charattr <= '0;
    else if (rv_nxt && ({1'b0, cell_index} < (CIW + 1)'(COLUMNS)))
      charattr <= bank_q[disp_nxt][cell_index];
    else
      charattr <= '0;

endmodule

// File: tb/tb_charattr_row_fetcher.sv
// Directed bench for charattr_row_fetcher (COLUMNS=4, ROWS=3, CHAR_HEIGHT=2).
// The memory model answers each request with word k = {addr[15:0], k},
// delivering at most mem_limit words of the current burst.
module tb_charattr_row_fetcher;
  logic        clk = 1'b0;
  logic        reset;
  logic        frame_start, line_start;
  logic [22:0] base_address;
  logic [1:0]  scroll_row;
  logic        rd_request;
  logic [22:0] rd_address;
  logic [8:0]  rd_burst_length;
  logic        rd_available;
  logic [31:0] rd_data;
  logic [1:0]  cell_index;
  logic [31:0] charattr;
  logic [0:0]  char_row;
  logic        row_valid, underrun, fetch_error;

  charattr_row_fetcher #(
    .COLUMNS(4), .ROWS(3), .CHAR_HEIGHT(2), .ADDR_WIDTH(23),
    .DATA_WIDTH(32), .ROW_STRIDE(512), .TIMEOUT(255)
  ) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .line_start(line_start),
    .base_address(base_address), .scroll_row(scroll_row),
    .rd_request(rd_request), .rd_address(rd_address),
    .rd_burst_length(rd_burst_length), .rd_available(rd_available),
    .rd_data(rd_data), .cell_index(cell_index), .charattr(charattr),
    .char_row(char_row), .row_valid(row_valid), .underrun(underrun),
    .fetch_error(fetch_error)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- memory model ----------------
  int          mem_limit = 4;
  int          req_cnt   = 0;
  logic [22:0] req_log [64];
  initial begin
    logic [22:0] cur_addr;
    int k, gap;
    cur_addr = '0; k = 4; gap = 0;
    rd_available = 1'b0;
    rd_data      = '0;
    forever begin
      @(negedge clk);
      rd_available = 1'b0;
      if (rd_request) begin
        req_log[req_cnt] = rd_address;
        req_cnt++;
        cur_addr = rd_address;
        k = 0;
        gap = 2;
      end else if (gap > 0) begin
        gap--;
      end else if (k < 4 && k < mem_limit) begin
        rd_available = 1'b1;
        rd_data      = {cur_addr[15:0], 16'(k)};
        k++;
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  // ---------------- helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_ls();
    line_start = 1'b1;
    tick(1);
    line_start = 1'b0;
  endtask

  task automatic start_frame(input logic [1:0] s);
    scroll_row   = s;
    base_address = 23'h1000;
    frame_start  = 1'b1;
    tick(1);
    frame_start  = 1'b0;
    tick(12);
  endtask

  // Six lines of a full frame; display row r must hold burst from ea[r].
  task automatic run_frame(input logic [22:0] a0, input logic [22:0] a1, input logic [22:0] a2);
    logic [22:0] ea [3];
    ea[0] = a0; ea[1] = a1; ea[2] = a2;
    for (int ln = 0; ln < 6; ln++) begin
      pulse_ls();
      check("char_row", 32'(char_row), 32'(ln % 2));
      check("row_valid", 32'(row_valid), 32'd1);
      cell_index = 2'(ln % 4);
      tick(1);
      check("charattr", charattr, {ea[ln / 2][15:0], 16'(ln % 4)});
      tick(10);
    end
  endtask

  task automatic check_reqs(input int b, input logic [22:0] a0, input logic [22:0] a1, input logic [22:0] a2);
    check("req_count", 32'(req_cnt - b), 32'd3);
    check("req_addr0", 32'(req_log[b]),     32'(a0));
    check("req_addr1", 32'(req_log[b + 1]), 32'(a1));
    check("req_addr2", 32'(req_log[b + 2]), 32'(a2));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int b, w;
    reset = 1'b0; frame_start = 1'b0; line_start = 1'b0;
    base_address = '0; scroll_row = '0; cell_index = '0;

    // reset state
    tick(2);
    check("rst_rd_request", 32'(rd_request), 32'd0);
    check("rst_rd_address", 32'(rd_address), 32'd0);
    check("rst_burst_len", 32'(rd_burst_length), 32'd4);
    check("rst_charattr", charattr, 32'd0);
    check("rst_char_row", 32'(char_row), 32'd0);
    check("rst_row_valid", 32'(row_valid), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    check("rst_fetch_error", 32'(fetch_error), 32'd0);
    reset = 1'b1;
    tick(4);

    // line_start before any frame_start is ignored
    pulse_ls();
    check("pre_frame_char_row", 32'(char_row), 32'd0);

    // nominal frame, scroll 0, with request latency
    b = req_cnt;
    scroll_row = 2'd0; base_address = 23'h1000; frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
    tick(1);
    check("req_latency", 32'(rd_request), 32'd1);
    check("req_addr_first", 32'(rd_address), 32'h1000);
    tick(11);
    run_frame(23'h1000, 23'h1200, 23'h1400);
    check_reqs(b, 23'h1000, 23'h1200, 23'h1400);

    // scroll wrap
    b = req_cnt;
    start_frame(2'd2);
    run_frame(23'h1400, 23'h1000, 23'h1200);
    check_reqs(b, 23'h1400, 23'h1000, 23'h1200);

    // out-of-range scroll reads as 0
    b = req_cnt;
    start_frame(2'd3);
    run_frame(23'h1000, 23'h1200, 23'h1400);
    check_reqs(b, 23'h1000, 23'h1200, 23'h1400);

    // underrun: second burst stalls after 2 words
    start_frame(2'd0);
    mem_limit = 2;
    pulse_ls();
    check("ur_row0_valid", 32'(row_valid), 32'd1);
    tick(11);
    pulse_ls();
    check("ur_char_row1", 32'(char_row), 32'd1);
    tick(3);
    b = req_cnt;
    pulse_ls();
    check("ur_pulse", 32'(underrun), 32'd1);
    check("ur_row_valid", 32'(row_valid), 32'd0);
    cell_index = 2'd2;
    tick(1);
    check("ur_charattr", charattr, 32'd0);
    check("ur_pulse_once", 32'(underrun), 32'd0);
    check("ur_no_req_before_drain", 32'(req_cnt - b), 32'd0);
    mem_limit = 4;
    w = 0;
    while (req_cnt == b && w < 30) begin tick(1); w++; end
    check("ur_req_after_drain", 32'(req_cnt - b), 32'd1);
    check("ur_req_addr", 32'(req_log[b]), 32'h1400);
    tick(12);
    pulse_ls();
    tick(2);
    pulse_ls();
    check("ur_row2_valid", 32'(row_valid), 32'd1);
    tick(1);
    check("ur_row2_charattr", charattr, 32'h1400_0002);

    // timeout: no data after the request
    mem_limit = 0;
    start_frame(2'd0);
    w = 0;
    while (!fetch_error && w < 400) begin tick(1); w++; end
    check("to_fetch_error", 32'(fetch_error), 32'd1);
    check("to_latency_ok", 32'(w >= 243 && w <= 247), 32'd1);
    tick(1);
    check("to_pulse_once", 32'(fetch_error), 32'd0);
    mem_limit = 4;   // late words arrive while idle
    tick(8);
    pulse_ls();
    check("to_row_valid", 32'(row_valid), 32'd0);
    check("to_underrun", 32'(underrun), 32'd1);
    cell_index = 2'd0;
    tick(1);
    check("to_charattr", charattr, 32'd0);
    tick(15);

    // simultaneous frame_start and line_start
    b = req_cnt;
    scroll_row = 2'd0; base_address = 23'h1000;
    frame_start = 1'b1; line_start = 1'b1;
    tick(1);
    frame_start = 1'b0; line_start = 1'b0;
    check("sim_char_row", 32'(char_row), 32'd0);
    tick(20);
    check("sim_req_count", 32'(req_cnt - b), 32'd1);
    check("sim_req_addr", 32'(req_log[b]), 32'h1000);
    mem_limit = 2;
    cell_index = 2'd1;
    pulse_ls();
    check("sim_row0_char_row", 32'(char_row), 32'd0);
    check("sim_row0_valid", 32'(row_valid), 32'd1);
    tick(1);
    check("sim_row0_charattr", charattr, 32'h1000_0001);
    tick(8);
    check("sim_next_req_addr", 32'(req_log[b + 1]), 32'h1200);

    // reset mid-burst
    reset = 1'b0;
    #1;
    check("mid_rst_rd_address", 32'(rd_address), 32'd0);
    check("mid_rst_charattr", charattr, 32'd0);
    check("mid_rst_row_valid", 32'(row_valid), 32'd0);
    check("mid_rst_rd_request", 32'(rd_request), 32'd0);
    tick(2);
    reset = 1'b1;
    tick(3);
    mem_limit = 4;   // rest of the old burst arrives after release
    tick(4);
    b = req_cnt;
    pulse_ls();
    check("post_rst_char_row", 32'(char_row), 32'd0);
    check("post_rst_row_valid", 32'(row_valid), 32'd0);
    tick(5);
    check("post_rst_no_req", 32'(req_cnt - b), 32'd0);
    start_frame(2'd0);
    run_frame(23'h1000, 23'h1200, 23'h1400);
    check_reqs(b, 23'h1000, 23'h1200, 23'h1400);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
